pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, 8..64.
REQ-002 SHALL derive localparam SHW = $clog2(WIDTH), the shift-amount width and pipeline depth.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  pipeline can accept a beat.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 SHALL have port in_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR/reserved.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_data  output  WIDTH  shifted result.
REQ-013 SHALL have port out_carry  output  1  last bit shifted out.

Function
REQ-014 SHALL implement SHW registered levels; level k shifts by 2^k when shamt[k]=1, else passes.
REQ-015 SHALL carry valid, type, remaining shamt and carry through every level with the data.
REQ-016 SHALL give latency SHW cycles from in_valid&&in_ready to out_valid, with no stall.
REQ-017 SHALL sustain one beat per cycle when out_ready is held high.
REQ-018 SHALL drive in_ready = !(out_valid && !out_ready), combinationally; stall freezes all levels.
REQ-019 SHALL never drop, duplicate or reorder beats; out_data/out_carry SHALL hold stable while out_valid&&!out_ready.
REQ-020 SHALL compute LSL = in<<s, LSR = in>>s (zero fill), ASR = sign fill from in[WIDTH-1].
REQ-021 SHALL set carry: LSL in[WIDTH-s]; LSR/ASR in[s-1]; ROR result[WIDTH-1]; s=0 gives carry 0.
REQ-022 SHALL treat bubbles (level valid=0) as don't-care data but keep valid=0 propagating.
REQ-023 SHALL accept a new beat in the same cycle the output beat is consumed (full pipeline, out_ready=1).

Reset
REQ-024 SHALL on rst_n=0 immediately clear all level valid bits, out_valid=0, out_data=0, out_carry=0.
REQ-025 SHALL discard in-flight beats on reset mid-operation; in_ready=1 during and after reset.
REQ-026 SHALL accept first beat on the first rising edge with rst_n=1.

Configuration
REQ-027 SHALL, with PIPE_SHIFTER_ROR_EN defined, perform rotate-right for type 11 (bits leaving bit 0 re-enter at bit WIDTH-1).
REQ-028 SHALL, without PIPE_SHIFTER_ROR_EN, pass type 11 data unchanged with carry 0, same latency.

Structure
REQ-029 SHALL place enum sh_type_e (SH_LSL, SH_LSR, SH_ASR, SH_ROR) in package shifter_pkg.
REQ-030 SHALL instantiate sub-module shift_level (parameter WIDTH, LEVEL) once per level via generate.
REQ-031 SHALL keep handshake/stall logic in pipe_shifter, not in shift_level.

Verification (WIDTH=32, SHW=5)
REQ-032 SHALL check LSL 0x8000_0001 s=1 -> out_data 0x0000_0002, carry 1, out_valid exactly 5 cycles after accept.
REQ-033 SHALL check ASR 0x8000_0000 s=31 -> 0xFFFF_FFFF carry 0; LSR same -> 0x0000_0001 carry 0.
REQ-034 SHALL check type 11 0x0000_0001 s=4 -> 0x1000_0000 carry 0 with macro; 0x0000_0001 carry 0 without.
REQ-035 SHALL check 20 back-to-back beats with out_ready toggling 1,0,0,1 -> all 20 results in order, in_ready low only when out_valid&&!out_ready.
REQ-036 SHALL check rst_n pulsed low with 3 beats in flight -> out_valid 0 asynchronously, no stale beat after release.
REQ-037 SHALL check s=0 for all four types on 0xA5A5_A5A5 -> data unchanged, carry 0.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift type encoding shared by pipe_shifter and shift_level
`timescale 1ns/1ps
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_type_e;

    localparam int SH_TYPE_W = 2;

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one registered barrel level shifting by 2^LEVEL; PIPE_SHIFTER_ROR_EN enables rotate
`timescale 1ns/1ps
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [SH_TYPE_W-1:0]     in_type,
    input  logic                     in_carry,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] out_shamt,
    output logic [SH_TYPE_W-1:0]     out_type,
    output logic                     out_carry
);

    localparam int STEP = 1 << LEVEL;

    logic [WIDTH-1:0] nxt_data;
    logic             nxt_carry;

    // Carry is the last bit shifted out by the last level that actually shifts,
    // which composes to the whole-shift carry once all levels are applied.
    always_comb begin
        nxt_data  = in_data;
        nxt_carry = in_carry;
        if (in_shamt[LEVEL]) begin
            case (sh_type_e'(in_type))
                SH_LSL: begin
                    nxt_data  = in_data << STEP;
                    nxt_carry = in_data[WIDTH-STEP];
                end
                SH_LSR: begin
                    nxt_data  = in_data >> STEP;
                    nxt_carry = in_data[STEP-1];
                end
                SH_ASR: begin
                    nxt_data  = $unsigned($signed(in_data) >>> STEP);
                    nxt_carry = in_data[STEP-1];
                end
                SH_ROR: begin
`ifdef PIPE_SHIFTER_ROR_EN
                    nxt_data  = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
                    nxt_carry = in_data[STEP-1];
`else
                    nxt_data  = in_data;
                    nxt_carry = 1'b0;
`endif
                end
                default: begin
                    nxt_data  = in_data;
                    nxt_carry = in_carry;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_type  <= '0;
            out_carry <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= nxt_data;
            out_shamt <= in_shamt;
            out_type  <= in_type;
            out_carry <= nxt_carry;
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - log2(WIDTH)-deep pipelined barrel shifter with valid/ready; PIPE_SHIFTER_ROR_EN enables rotate
`timescale 1ns/1ps
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SHW-1:0]       in_shamt,
    input  logic [SH_TYPE_W-1:0] in_type,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_carry
);

    logic                 lv_valid [SHW+1];
    logic [WIDTH-1:0]     lv_data  [SHW+1];
    logic [SHW-1:0]       lv_shamt [SHW+1];
    logic [SH_TYPE_W-1:0] lv_type  [SHW+1];
    logic                 lv_carry [SHW+1];
    logic                 adv;
    logic                 unused_tail;

    // The only stall point is the output register; when it holds an
    // unconsumed beat every level freezes together.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    assign lv_valid[0] = in_valid;
    assign lv_data[0]  = in_data;
    assign lv_shamt[0] = in_shamt;
    assign lv_type[0]  = in_type;
    assign lv_carry[0] = 1'b0;

    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_level
            shift_level #(
                .WIDTH (WIDTH),
                .LEVEL (k)
            ) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (adv),
                .in_valid  (lv_valid[k]),
                .in_data   (lv_data[k]),
                .in_shamt  (lv_shamt[k]),
                .in_type   (lv_type[k]),
                .in_carry  (lv_carry[k]),
                .out_valid (lv_valid[k+1]),
                .out_data  (lv_data[k+1]),
                .out_shamt (lv_shamt[k+1]),
                .out_type  (lv_type[k+1]),
                .out_carry (lv_carry[k+1])
            );
        end
    endgenerate

    assign out_valid = lv_valid[SHW];
    assign out_data  = lv_data[SHW];
    assign out_carry = lv_carry[SHW];

    assign unused_tail = ^{lv_shamt[SHW], lv_type[SHW]};

endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - scoreboard bench for pipe_shifter (WIDTH=32); honours PIPE_SHIFTER_ROR_EN
`timescale 1ns/1ps
module tb_pipe_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_type = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_carry;

    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q [$];
    logic        pat_en = 1'b0;
    int          pidx = 0;
    logic [3:0]  pat = 4'b1001;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_c = 1'b0;

    pipe_shifter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_type   (in_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] ref_shift(input logic [31:0] a, input int s, input logic [1:0] t);
        logic [31:0] d;
        logic        c;
        d = a;
        c = 1'b0;
        case (t)
            2'b00: begin d = a << s; if (s != 0) c = a[32-s]; end
            2'b01: begin d = a >> s; if (s != 0) c = a[s-1]; end
            2'b10: begin d = $unsigned($signed(a) >>> s); if (s != 0) c = a[s-1]; end
            default: begin
`ifdef PIPE_SHIFTER_ROR_EN
                if (s != 0) begin d = (a >> s) | (a << (32 - s)); c = d[31]; end
`endif
            end
        endcase
        return {c, d};
    endfunction

    // Caller is at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] t,
                        input logic [31:0] ed, input logic ec);
        int guard;
        logic acc;
        guard = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_type  = t;
        while (!acc && guard < 200) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({ec, ed});
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (pat_en) begin
            out_ready = pat[3-pidx];
            pidx = (pidx + 1) % 4;
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (hold_prev && out_valid) begin
                check("hold_data", 64'(out_data), 64'(hold_d));
                check("hold_carry", 64'(out_carry), 64'(hold_c));
            end
            hold_prev = out_valid && !out_ready;
            hold_d    = out_data;
            hold_c    = out_carry;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat actual=%0h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e[31:0]));
                    check("out_carry", 64'(out_carry), 64'(e[32]));
                end
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        int n;
        int cnt;
        logic [31:0] a;
        logic [4:0]  s;
        logic [1:0]  t;
        logic [32:0] r;

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(32'h8000_0001, 5'd1, 2'b00, 32'h0000_0002, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("latency", 64'(n), 64'd5);
        drain();

        send(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0);
        send(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 1'b0);
`ifdef PIPE_SHIFTER_ROR_EN
        send(32'h0000_0001, 5'd4, 2'b11, 32'h1000_0000, 1'b0);
`else
        send(32'h0000_0001, 5'd4, 2'b11, 32'h0000_0001, 1'b0);
`endif
        send(32'hA5A5_A5A5, 5'd0, 2'b00, 32'hA5A5_A5A5, 1'b0);
        send(32'hA5A5_A5A5, 5'd0, 2'b01, 32'hA5A5_A5A5, 1'b0);
        send(32'hA5A5_A5A5, 5'd0, 2'b10, 32'hA5A5_A5A5, 1'b0);
        send(32'hA5A5_A5A5, 5'd0, 2'b11, 32'hA5A5_A5A5, 1'b0);
        send(32'h0000_000F, 5'd4, 2'b01, 32'h0000_0000, 1'b1);
        send(32'h0F00_0000, 5'd5, 2'b00, 32'hE000_0000, 1'b1);
        drain();

        pidx = 0;
        pat_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 32'h1234_5678 ^ (32'(i) * 32'h0107_0301);
            s = 5'((i * 7) % 32);
            t = 2'(i % 4);
            r = ref_shift(a, int'(s), t);
            send(a, s, t, r[31:0], r[32]);
        end
        drain();
        pat_en = 1'b0;
        out_ready = 1'b1;

        out_ready = 1'b0;
        send(32'h0000_00F0, 5'd2, 2'b00, 32'h0000_03C0, 1'b0);
        send(32'h0000_00F0, 5'd3, 2'b01, 32'h0000_001E, 1'b0);
        send(32'hF000_0000, 5'd4, 2'b10, 32'hFF00_0000, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", 64'(out_data), 64'd0);
        check("async_out_carry", 64'(out_carry), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("stale_beats", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        send(32'h0000_0100, 5'd8, 2'b01, 32'h0000_0001, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
